// File: rtl/wxr_grad_update.sv
`default_nettype none
// ============================================================================
// Module   : wxr_grad_update
// Brief    : Weights per-cell dh/dW(xr) sensitivities by dL/dh, accumulates
//            them over a BPTT sequence and applies an SGD step on the last beat.
// Revision : 1.0  initial release
// ============================================================================
module wxr_grad_update #(
    parameter int DATABIT = 16,
    parameter int FRAC    = 12,
    parameter int CELLNUM = 4,
    parameter int ACCW    = 2*DATABIT+4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      first,
    input  logic                      last,
    input  logic signed [DATABIT-1:0] dh0_dw,
    input  logic signed [DATABIT-1:0] dh1_dw,
    input  logic signed [DATABIT-1:0] dh2_dw,
    input  logic signed [DATABIT-1:0] dh3_dw,
    input  logic signed [DATABIT-1:0] err0,
    input  logic signed [DATABIT-1:0] err1,
    input  logic signed [DATABIT-1:0] err2,
    input  logic signed [DATABIT-1:0] err3,
    input  logic signed [DATABIT-1:0] lr,
    input  logic signed [DATABIT-1:0] w_in,
    output logic signed [DATABIT-1:0] dh0_fb,
    output logic signed [DATABIT-1:0] dh1_fb,
    output logic signed [DATABIT-1:0] dh2_fb,
    output logic signed [DATABIT-1:0] dh3_fb,
    output logic signed [DATABIT-1:0] grad_out,
    output logic signed [DATABIT-1:0] w_out,
    output logic                      w_valid
);

    localparam int c_PORTS = 4;
    localparam int c_PW    = 2*DATABIT;
    localparam int c_IDXW  = (CELLNUM > 1) ? $clog2(CELLNUM) : 1;

    localparam logic [c_IDXW-1:0]  c_IDX_LAST = c_IDXW'(CELLNUM-1);
    localparam logic [DATABIT-1:0] c_SAT_MAX  = {1'b0, {(DATABIT-1){1'b1}}};
    localparam logic [DATABIT-1:0] c_SAT_MIN  = {1'b1, {(DATABIT-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_UPD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATABIT-1:0] w_dh_in  [c_PORTS];
    logic signed [DATABIT-1:0] w_err_in [c_PORTS];
    logic signed [DATABIT-1:0] r_dh     [c_PORTS];
    logic signed [DATABIT-1:0] r_err    [c_PORTS];
    logic signed [DATABIT-1:0] r_fb     [c_PORTS];

    logic                      r_last;
    logic signed [DATABIT-1:0] r_lr;
    logic signed [DATABIT-1:0] r_w_in;
    logic signed [ACCW-1:0]    r_acc;
    logic [c_IDXW-1:0]         r_idx;
    logic signed [DATABIT-1:0] r_grad;
    logic signed [DATABIT-1:0] r_w_out;
    logic                      r_w_valid;

    logic                      w_accept;
    logic signed [c_PW-1:0]    w_prod;
    logic signed [c_PW-1:0]    w_term;
    logic signed [ACCW-1:0]    w_acc_sum;
    logic                      w_acc_fits;
    logic signed [DATABIT-1:0] w_grad;
    logic signed [c_PW-1:0]    w_step_prod;
    logic signed [c_PW-1:0]    w_step;
    logic signed [c_PW:0]      w_diff;
    logic                      w_diff_fits;
    logic signed [DATABIT-1:0] w_w_new;

    assign w_dh_in[0]  = dh0_dw;
    assign w_dh_in[1]  = dh1_dw;
    assign w_dh_in[2]  = dh2_dw;
    assign w_dh_in[3]  = dh3_dw;
    assign w_err_in[0] = err0;
    assign w_err_in[1] = err1;
    assign w_err_in[2] = err2;
    assign w_err_in[3] = err3;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;

    // One cell per cycle; the floor shift happens on the full product.
    always_comb begin
        w_prod    = r_dh[r_idx] * r_err[r_idx];
        w_term    = w_prod >>> FRAC;
        w_acc_sum = r_acc + {{(ACCW-c_PW){w_term[c_PW-1]}}, w_term};
    end

    // The accumulator fits the output word when all bits above the sign agree.
    always_comb begin
        w_acc_fits = (&r_acc[ACCW-1:DATABIT-1]) | ~(|r_acc[ACCW-1:DATABIT-1]);
        if (w_acc_fits) begin
            w_grad = r_acc[DATABIT-1:0];
        end else if (r_acc[ACCW-1]) begin
            w_grad = c_SAT_MIN;
        end else begin
            w_grad = c_SAT_MAX;
        end
    end

    always_comb begin
        w_step_prod = r_lr * w_grad;
        w_step      = w_step_prod >>> FRAC;
        w_diff      = {{(DATABIT+1){r_w_in[DATABIT-1]}}, r_w_in}
                    - {w_step[c_PW-1], w_step};
        w_diff_fits = (&w_diff[c_PW:DATABIT-1]) | ~(|w_diff[c_PW:DATABIT-1]);
        if (w_diff_fits) begin
            w_w_new = w_diff[DATABIT-1:0];
        end else if (w_diff[c_PW]) begin
            w_w_new = c_SAT_MIN;
        end else begin
            w_w_new = c_SAT_MAX;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = r_last ? ST_UPD : ST_IDLE;
                end
            end
            ST_UPD:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b0;
            r_lr      <= '0;
            r_w_in    <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_grad    <= '0;
            r_w_out   <= '0;
            r_w_valid <= 1'b0;
            for (int i = 0; i < c_PORTS; i++) begin
                r_dh[i]  <= '0;
                r_err[i] <= '0;
                r_fb[i]  <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_w_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last <= last;
                        r_lr   <= lr;
                        r_w_in <= w_in;
                        r_idx  <= '0;
                        if (first) begin
                            r_acc <= '0;
                        end
                        // A last beat ends the sequence, so the next one starts with no history.
                        for (int i = 0; i < c_PORTS; i++) begin
                            r_dh[i]  <= w_dh_in[i];
                            r_err[i] <= w_err_in[i];
                            r_fb[i]  <= last ? '0 : w_dh_in[i];
                        end
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_sum;
                    r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDXW'(1);
                end
                ST_UPD: begin
                    r_grad    <= w_grad;
                    r_w_out   <= w_w_new;
                    r_w_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dh0_fb   = r_fb[0];
    assign dh1_fb   = r_fb[1];
    assign dh2_fb   = r_fb[2];
    assign dh3_fb   = r_fb[3];
    assign grad_out = r_grad;
    assign w_out    = r_w_out;
    assign w_valid  = r_w_valid;

endmodule
`default_nettype wire

// File: tb/tb_wxr_grad_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_wxr_grad_update
// Brief    : Self-checking bench for wxr_grad_update against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wxr_grad_update;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               first = 1'b0;
    logic               last = 1'b0;
    logic signed [15:0] dh [4];
    logic signed [15:0] er [4];
    logic signed [15:0] lr = '0;
    logic signed [15:0] w_in = '0;
    logic signed [15:0] fb [4];
    logic signed [15:0] grad_out;
    logic signed [15:0] w_out;
    logic               w_valid;

    int     n_cmp = 0;
    int     n_err = 0;
    longint m_acc = 0;
    longint m_fb [4];
    longint m_exp_g = 0;
    longint m_exp_w = 0;

    wxr_grad_update dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .first(first), .last(last),
        .dh0_dw(dh[0]), .dh1_dw(dh[1]), .dh2_dw(dh[2]), .dh3_dw(dh[3]),
        .err0(er[0]), .err1(er[1]), .err2(er[2]), .err3(er[3]),
        .lr(lr), .w_in(w_in),
        .dh0_fb(fb[0]), .dh1_fb(fb[1]), .dh2_fb(fb[2]), .dh3_fb(fb[3]),
        .grad_out(grad_out), .w_out(w_out), .w_valid(w_valid)
    );

    function automatic longint floor_div(longint a, longint b);
        longint q = a / b;
        if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint sat16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic set_cells(input longint d0, e0, input longint d_rest, e_rest);
        dh[0] = 16'(d0); er[0] = 16'(e0);
        for (int i = 1; i < 4; i++) begin
            dh[i] = 16'(d_rest); er[i] = 16'(e_rest);
        end
    endtask

    // Presents one beat, returns at the falling edge right after acceptance.
    task automatic send_beat(input bit f, input bit l, input longint lr_v, input longint w_v);
        int k = 0;
        while (!in_ready && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (k >= 30) begin
            n_cmp++; n_err++;
            $display("FAIL beat_accept: in_ready never rose, got %0d required 1", in_ready);
        end
        first = f; last = l; lr = 16'(lr_v); w_in = 16'(w_v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (f) m_acc = 0;
        for (int i = 0; i < 4; i++) begin
            m_acc += floor_div(longint'(dh[i]) * longint'(er[i]), 4096);
            m_fb[i] = l ? 0 : longint'(dh[i]);
        end
        if (l) begin
            m_exp_g = sat16(m_acc);
            m_exp_w = sat16(w_v - floor_div(lr_v * m_exp_g, 4096));
        end
    endtask

    task automatic wait_wvalid(output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (w_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int wv_seen = 0;
        int changes = 0;
        n_cmp++;
        if (in_ready !== 1'b1 || w_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got ready=%0d wv=%0d required ready=1 wv=0", in_ready, w_valid);
        end
        n_cmp++;
        if (grad_out !== 16'sd0 || w_out !== 16'sd0) begin
            n_err++;
            $display("FAIL reset_data: got grad=%0d w=%0d required 0 0", grad_out, w_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (fb[i] !== 16'sd0) begin
                n_err++;
                $display("FAIL reset_fb%0d: got %0d required 0", i, fb[i]);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (w_valid) wv_seen++;
            if (grad_out !== 16'sd0 || w_out !== 16'sd0 || fb[0] !== 16'sd0 || in_ready !== 1'b1) changes++;
        end
        n_cmp++;
        if (wv_seen != 0 || changes != 0) begin
            n_err++;
            $display("FAIL idle_quiet: got wv=%0d changes=%0d required 0 0", wv_seen, changes);
        end
    endtask

    task automatic test_single_step;
        int lat;
        set_cells(4096, 1024, 4096, 1024);
        send_beat(1'b1, 1'b1, 4096, 8192);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (fb[i] !== 16'sd0) begin
                n_err++;
                $display("FAIL single_fb%0d: got %0d required 0", i, fb[i]);
            end
        end
        wait_wvalid(lat);
        n_cmp++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL single_latency: got %0d required 5", lat);
        end
        n_cmp++;
        if (grad_out !== 16'sd4096 || w_out !== 16'sd4096) begin
            n_err++;
            $display("FAIL single_result: got grad=%0d w=%0d required 4096 4096", grad_out, w_out);
        end
        @(negedge clk);
        n_cmp++;
        if (w_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_pulse: got wv=%0d ready=%0d required 0 1", w_valid, in_ready);
        end
    endtask

    task automatic test_three_step;
        int lat;
        int lowc;
        int wv_seen;
        set_cells(2048, 2048, 0, 0);
        for (int b = 0; b < 2; b++) begin
            send_beat(b == 0, 1'b0, 2048, 0);
            lowc = 0; wv_seen = 0;
            while (!in_ready && lowc < 20) begin
                lowc++;
                if (w_valid) wv_seen++;
                @(negedge clk);
            end
            n_cmp++;
            if (lowc != 4 || wv_seen != 0) begin
                n_err++;
                $display("FAIL three_busy%0d: got low=%0d wv=%0d required 4 0", b, lowc, wv_seen);
            end
            n_cmp++;
            if (fb[0] !== 16'sd2048 || grad_out !== 16'sd4096) begin
                n_err++;
                $display("FAIL three_fb%0d: got fb0=%0d grad=%0d required 2048 4096", b, fb[0], grad_out);
            end
        end
        send_beat(1'b0, 1'b1, 2048, 0);
        n_cmp++;
        if (fb[0] !== 16'sd0) begin
            n_err++;
            $display("FAIL three_fb_last: got %0d required 0", fb[0]);
        end
        wait_wvalid(lat);
        n_cmp++;
        if (lat != 5 || grad_out !== 16'sd3072 || w_out !== -16'sd1536) begin
            n_err++;
            $display("FAIL three_result: got lat=%0d grad=%0d w=%0d required 5 3072 -1536", lat, grad_out, w_out);
        end
    endtask

    task automatic test_saturation;
        int lat;
        set_cells(32767, 32767, 32767, 32767);
        send_beat(1'b1, 1'b1, 4096, -32768);
        wait_wvalid(lat);
        n_cmp++;
        if (lat != 5 || grad_out !== 16'sd32767 || w_out !== -16'sd32768) begin
            n_err++;
            $display("FAIL saturation: got lat=%0d grad=%0d w=%0d required 5 32767 -32768", lat, grad_out, w_out);
        end
    endtask

    task automatic test_neg_floor;
        int lat;
        set_cells(-1, 1, 0, 0);
        send_beat(1'b1, 1'b1, 4096, 0);
        wait_wvalid(lat);
        n_cmp++;
        if (lat != 5 || grad_out !== -16'sd1 || w_out !== 16'sd1) begin
            n_err++;
            $display("FAIL neg_floor: got lat=%0d grad=%0d w=%0d required 5 -1 1", lat, grad_out, w_out);
        end
    endtask

    task automatic test_random;
        int lat;
        int len;
        bit f;
        for (int s = 0; s < 14; s++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < 4; i++) begin
                    dh[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom()) : 16'($urandom_range(0, 8192) - 4096);
                    er[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom()) : 16'($urandom_range(0, 8192) - 4096);
                end
                f = (b == 0) && ($urandom_range(0, 3) != 0);
                send_beat(f, b == len - 1, longint'($signed(16'($urandom()))), longint'($signed(16'($urandom()))));
                for (int i = 0; i < 4; i++) begin
                    n_cmp++;
                    if (longint'(fb[i]) != m_fb[i]) begin
                        n_err++;
                        $display("FAIL rand_fb s%0d b%0d c%0d: got %0d required %0d", s, b, i, fb[i], m_fb[i]);
                    end
                end
            end
            wait_wvalid(lat);
            n_cmp++;
            if (lat != 5 || longint'(grad_out) != m_exp_g || longint'(w_out) != m_exp_w) begin
                n_err++;
                $display("FAIL rand_result s%0d: got lat=%0d grad=%0d w=%0d required 5 %0d %0d",
                         s, lat, grad_out, w_out, m_exp_g, m_exp_w);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc_cnt = 0;
        set_cells(300, 500, -700, 900);
        first = 1'b1; last = 1'b0; lr = 16'sd100; w_in = 16'sd0;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) acc_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        m_acc = 0;
        for (int i = 0; i < 4; i++) begin
            m_acc += floor_div(longint'(dh[i]) * longint'(er[i]), 4096);
            m_fb[i] = longint'(dh[i]);
        end
        n_cmp++;
        if (acc_cnt != 4) begin
            n_err++;
            $display("FAIL busy_accepts: got %0d required 4", acc_cnt);
        end
        n_cmp++;
        if (longint'(fb[2]) != m_fb[2] || w_valid !== 1'b0) begin
            n_err++;
            $display("FAIL busy_fb: got fb2=%0d wv=%0d required %0d 0", fb[2], w_valid, m_fb[2]);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int wv_seen = 0;
        int not_ready = 0;
        set_cells(4096, 1024, 4096, 1024);
        send_beat(1'b1, 1'b1, 4096, 8192);
        wait_wvalid(lat);
        n_cmp++;
        if (lat != 5 || grad_out !== 16'sd4096) begin
            n_err++;
            $display("FAIL pre_reset: got lat=%0d grad=%0d required 5 4096", lat, grad_out);
        end
        set_cells(8192, 4096, 8192, 4096);
        send_beat(1'b1, 1'b0, 4096, 1000);
        send_beat(1'b0, 1'b1, 4096, 1000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (grad_out !== 16'sd0 || w_out !== 16'sd0 || fb[0] !== 16'sd0 || w_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got grad=%0d w=%0d fb0=%0d wv=%0d ready=%0d required 0 0 0 0 1",
                     grad_out, w_out, fb[0], w_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        for (int i = 0; i < 4; i++) m_fb[i] = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (w_valid) wv_seen++;
            if (!in_ready) not_ready++;
        end
        n_cmp++;
        if (wv_seen != 0 || not_ready != 0) begin
            n_err++;
            $display("FAIL post_reset: got wv=%0d not_ready=%0d required 0 0", wv_seen, not_ready);
        end
        // Last without first after reset sums onto the cleared accumulator.
        set_cells(4096, 1024, 4096, 1024);
        send_beat(1'b0, 1'b1, 4096, 8192);
        wait_wvalid(lat);
        n_cmp++;
        if (lat != 5 || grad_out !== 16'sd4096 || w_out !== 16'sd4096) begin
            n_err++;
            $display("FAIL last_no_first: got lat=%0d grad=%0d w=%0d required 5 4096 4096", lat, grad_out, w_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            dh[i] = '0; er[i] = '0; m_fb[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_step();
        test_three_step();
        test_saturation();
        test_neg_floor();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wxr_grad_update.md
# wxr_grad_update

Downstream stage of the dh/dW(xr) datapath. Consumes one timestep's CELLNUM per-cell sensitivities dh_t/dW for one weight element, weights them by the per-cell loss error dL/dh_t, and accumulates over a BPTT sequence. On the sequence's last step it applies an SGD update to the weight. It also registers the accepted sensitivities for feedback as next step's dh_{t-1}/dW.

## Interface
- DATABIT, 16, signed fixed-point word width
- FRAC, 12, fractional bits (Q4.12 at defaults; 1.0 = 4096)
- CELLNUM, 4, hidden cells per step (ports below are written for 4)
- ACCW, 2*DATABIT+4, internal accumulator width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  step data valid
- in_ready  out  1  high only in IDLE
- first  in  1  with beat: clear accumulator before summing
- last  in  1  with beat: apply weight update after summing
- dh0_dw..dh3_dw  in  DATABIT each, signed  dh_t/dW per cell
- err0..err3  in  DATABIT each, signed  dL/dh_t per cell
- lr  in  DATABIT, signed  learning rate, sampled on last beat
- w_in  in  DATABIT, signed  current weight, sampled on last beat
- dh0_fb..dh3_fb  out  DATABIT each, signed  registered dh/dW feedback
- grad_out  out  DATABIT, signed  saturated accumulated gradient
- w_out  out  DATABIT, signed  updated weight
- w_valid  out  1  one-cycle pulse, grad_out/w_out new

## Operation
- States: IDLE, MAC, UPD.
- IDLE: in_ready=1. Accept = in_valid & in_ready. On accept, capture dh*, err*, first, last, lr, w_in. If first, acc <- 0. Load idx=0 and go to MAC.
- MAC: one cell per cycle, idx 0..CELLNUM-1: acc <- acc + ((dh_idx * err_idx) >>> FRAC).
  - Full 2*DATABIT product; arithmetic shift floors toward -inf.
  - No saturation inside acc.
  - After idx=CELLNUM-1: go to UPD if last, else go to IDLE.
- UPD (one cycle):
  - g = sat(acc)
  - step = (lr * g) >>> FRAC
  - w_out <- sat(w_in - step) over full width
  - grad_out <- g
  - w_valid <- 1
  - Go to IDLE.
- sat(): clamp to [-2^(DATABIT-1), 2^(DATABIT-1)-1].
- Feedback: on accept, dh*_fb <- 0 if last, else dh*_fb <- dh*_dw. The next sequence therefore starts from zero history.
- Beats only enter in IDLE. in_valid while busy is not accepted; upstream holds data.
- first & last on the same beat: single-step sequence, legal.
- last without a prior first: sums onto the existing acc.
- grad_out/w_out hold their values until the next UPD.

## Timing
- Reset: state IDLE, acc 0, idx 0.
- Reset values of outputs: in_ready 1; all dh*_fb, grad_out, w_out 0; w_valid 0.
- Accept at edge E0. MAC at edges E1..E4.
- Non-last beat: in_ready is high again in the cycle after E4 (5-cycle beat period).
- Last beat: UPD at E5. w_valid is high during the cycle after E5. in_ready returns at the same time; the next accept is at E6 at the earliest.
- w_valid is never high on two consecutive cycles.
- dh*_fb change at E0 of each accept.
- Reset asserted mid-MAC or mid-UPD: immediate return to reset values. No w_valid pulse. The partial sum is discarded.

## Test plan
- Reset release:
  - Outputs all 0, in_ready=1.
  - in_valid=0 for 20 cycles -> no w_valid, no change.
- Single step, first=last=1:
  - Stimulus: dh*=4096, err*=1024, lr=4096, w_in=8192.
  - Response: w_valid one cycle after E5, grad_out=4096, w_out=4096, dh*_fb=0.
- Three-step sequence (first on beat 1, last on beat 3):
  - Stimulus: each beat dh0=2048, err0=2048, other cells 0; lr=2048, w_in=0.
  - Response: grad_out=3072, w_out=-1536.
  - in_ready low exactly 4 cycles per non-last beat; dh0_fb=2048 after beats 1-2.
- Saturation, one step:
  - Stimulus: dh*=32767, err*=32767, lr=4096, w_in=-32768.
  - Response: acc=1048508, grad_out=32767, w_out=-32768.
- Negative floor:
  - Stimulus: dh0=-1, err0=1, others 0, lr=4096, w_in=0.
  - Response: grad_out=-1, w_out=1.
- Busy/reset:
  - in_valid held high through MAC -> exactly one accept per 5 cycles.
  - rst_n pulsed low at E2 of a last beat -> no w_valid; outputs 0; in_ready=1 after release.
